aq_axi_sdma64_arb: RTL and testbench

AQ_AXI_SDMA64_ARB -- requirements
Module: aq_axi_sdma64_arb

---
 rtl/aq_axi_sdma64_arb.sv | 161 ++++++++++++++++
 tb/tb_aq_axi_sdma64_arb.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_axi_sdma64_arb.sv
// Two-requester round-robin arbiters (write and read) in front of a single-job
// DMA engine: each channel grants one requester, starts the engine, waits for completion.

module aq_axi_sdma64_arb_ch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_i,
  input  logic [63:0] req_adrs_i,
  input  logic [63:0] req_len_i,
  input  logic        ready_i,
  input  logic        int_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic        err_o,
  output logic        start_o,
  output logic [31:0] adrs_o,
  output logic [31:0] len_o,
  output logic [15:0] count_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        ptr_q, ptr_d;
  logic        err_q, err_d;
  logic [31:0] adrs_q, adrs_d;
  logic [31:0] len_q, len_d;
  logic [15:0] count_q, count_d;

  logic        win;
  logic [31:0] win_adrs;
  logic [31:0] win_len;

  // Both requesting: the pointer decides; otherwise the lone requester wins.
  always_comb begin
    win      = (req_i == 2'b11) ? ptr_q : req_i[1];
    win_adrs = win ? req_adrs_i[63:32] : req_adrs_i[31:0];
    win_len  = win ? req_len_i[63:32]  : req_len_i[31:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= 1'b0;
      err_q   <= 1'b0;
      adrs_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      adrs_q  <= adrs_d;
      len_q   <= len_d;
      count_q <= count_d;
    end
  end

  // NOTE: every signal gets a hold-value default first, so no path through the
  // case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    adrs_d  = adrs_q;
    len_d   = len_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (ready_i && (req_i != 2'b00)) begin
          gnt_d   = win ? 2'b10 : 2'b01;
          adrs_d  = win_adrs;
          len_d   = win_len;
          err_d   = (win_len == 32'd0);
          state_d = (win_len == 32'd0) ? S_DONE : S_START;
        end
      end
      S_START: state_d = S_BUSY;
      S_BUSY: begin
        if (int_i) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        ptr_d   = ~gnt_q[1];
        err_d   = 1'b0;
        if (!err_q) count_d = count_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_o   = gnt_q;
    start_o = (state_q == S_START);
    done_o  = (state_q == S_DONE) ? gnt_q : 2'b00;
    err_o   = (state_q == S_DONE) && err_q;
    adrs_o  = adrs_q;
    len_o   = len_q;
    count_o = count_q;
  end

endmodule

module aq_axi_sdma64_arb (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [1:0]  WR_REQ,
  input  logic [63:0] WR_REQ_ADRS,
  input  logic [63:0] WR_REQ_LEN,
  input  logic [1:0]  WR_REQ_LAST,
  output logic [1:0]  WR_GNT,
  output logic [1:0]  WR_DONE,
  output logic        WR_ERR,
  input  logic [1:0]  RD_REQ,
  input  logic [63:0] RD_REQ_ADRS,
  input  logic [63:0] RD_REQ_LEN,
  output logic [1:0]  RD_GNT,
  output logic [1:0]  RD_DONE,
  output logic        RD_ERR,
  output logic        WR_START,
  output logic [31:0] WR_ADRS,
  output logic [31:0] WR_LEN,
  output logic        WR_LAST,
  input  logic        WR_READY,
  input  logic        WR_INT,
  output logic        RD_START,
  output logic [31:0] RD_ADRS,
  output logic [31:0] RD_LEN,
  input  logic        RD_READY,
  input  logic        RD_INT,
  output logic [15:0] WR_COUNT,
  output logic [15:0] RD_COUNT
);

  aq_axi_sdma64_arb_ch u_wr (
    .clk(ACLK), .rst_n(ARESETN),
    .req_i(WR_REQ), .req_adrs_i(WR_REQ_ADRS), .req_len_i(WR_REQ_LEN),
    .ready_i(WR_READY), .int_i(WR_INT),
    .gnt_o(WR_GNT), .done_o(WR_DONE), .err_o(WR_ERR), .start_o(WR_START),
    .adrs_o(WR_ADRS), .len_o(WR_LEN), .count_o(WR_COUNT)
  );

  aq_axi_sdma64_arb_ch u_rd (
    .clk(ACLK), .rst_n(ARESETN),
    .req_i(RD_REQ), .req_adrs_i(RD_REQ_ADRS), .req_len_i(RD_REQ_LEN),
    .ready_i(RD_READY), .int_i(RD_INT),
    .gnt_o(RD_GNT), .done_o(RD_DONE), .err_o(RD_ERR), .start_o(RD_START),
    .adrs_o(RD_ADRS), .len_o(RD_LEN), .count_o(RD_COUNT)
  );

  // Grant is one-hot or zero, so this follows the granted requester's level.
  assign WR_LAST = |(WR_GNT & WR_REQ_LAST);

endmodule

// File: tb/tb_aq_axi_sdma64_arb.sv
// Self-checking bench for aq_axi_sdma64_arb: vector table, directed corner
// sequences and a randomized job-level reference model per channel.

module tb_aq_axi_sdma64_arb;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [1:0]  WR_REQ, WR_REQ_LAST, RD_REQ;
  logic [63:0] WR_REQ_ADRS, WR_REQ_LEN, RD_REQ_ADRS, RD_REQ_LEN;
  logic        WR_READY, WR_INT, RD_READY, RD_INT;
  logic [1:0]  WR_GNT, WR_DONE, RD_GNT, RD_DONE;
  logic        WR_ERR, RD_ERR, WR_START, RD_START, WR_LAST;
  logic [31:0] WR_ADRS, WR_LEN, RD_ADRS, RD_LEN;
  logic [15:0] WR_COUNT, RD_COUNT;

  int checks = 0;
  int failures = 0;

  aq_axi_sdma64_arb dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .WR_REQ(WR_REQ), .WR_REQ_ADRS(WR_REQ_ADRS), .WR_REQ_LEN(WR_REQ_LEN),
    .WR_REQ_LAST(WR_REQ_LAST), .WR_GNT(WR_GNT), .WR_DONE(WR_DONE), .WR_ERR(WR_ERR),
    .RD_REQ(RD_REQ), .RD_REQ_ADRS(RD_REQ_ADRS), .RD_REQ_LEN(RD_REQ_LEN),
    .RD_GNT(RD_GNT), .RD_DONE(RD_DONE), .RD_ERR(RD_ERR),
    .WR_START(WR_START), .WR_ADRS(WR_ADRS), .WR_LEN(WR_LEN), .WR_LAST(WR_LAST),
    .WR_READY(WR_READY), .WR_INT(WR_INT),
    .RD_START(RD_START), .RD_ADRS(RD_ADRS), .RD_LEN(RD_LEN),
    .RD_READY(RD_READY), .RD_INT(RD_INT),
    .WR_COUNT(WR_COUNT), .RD_COUNT(RD_COUNT)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    WR_REQ = '0; WR_REQ_LAST = '0; RD_REQ = '0;
    WR_REQ_ADRS = '0; WR_REQ_LEN = '0; RD_REQ_ADRS = '0; RD_REQ_LEN = '0;
    WR_READY = 1'b0; WR_INT = 1'b0; RD_READY = 1'b0; RD_INT = 1'b0;
    repeat (2) tick();
    ARESETN = 1'b1;
    tick();
  endtask

  // Channel-indexed accessors: ch=0 write, ch=1 read.
  function automatic logic [1:0] gnt_of(input bit ch);    return ch ? RD_GNT : WR_GNT;     endfunction
  function automatic logic [1:0] done_of(input bit ch);   return ch ? RD_DONE : WR_DONE;   endfunction
  function automatic logic       err_of(input bit ch);    return ch ? RD_ERR : WR_ERR;     endfunction
  function automatic logic       start_of(input bit ch);  return ch ? RD_START : WR_START; endfunction
  function automatic logic [31:0] adrs_of(input bit ch);  return ch ? RD_ADRS : WR_ADRS;   endfunction
  function automatic logic [31:0] len_of(input bit ch);   return ch ? RD_LEN : WR_LEN;     endfunction
  function automatic logic [15:0] count_of(input bit ch); return ch ? RD_COUNT : WR_COUNT; endfunction

  task automatic set_req(input bit ch, input logic [1:0] r);
    if (ch) RD_REQ = r; else WR_REQ = r;
  endtask
  task automatic set_ready(input bit ch, input logic v);
    if (ch) RD_READY = v; else WR_READY = v;
  endtask
  task automatic set_int(input bit ch, input logic v);
    if (ch) RD_INT = v; else WR_INT = v;
  endtask
  task automatic set_job(input bit ch, input int idx, input logic [31:0] a, input logic [31:0] l);
    if (ch) begin
      RD_REQ_ADRS[idx*32 +: 32] = a;
      RD_REQ_LEN[idx*32 +: 32]  = l;
    end else begin
      WR_REQ_ADRS[idx*32 +: 32] = a;
      WR_REQ_LEN[idx*32 +: 32]  = l;
    end
  endtask

  typedef struct {
    logic        ready;
    logic [1:0]  req;
    logic [31:0] len0;
    logic [31:0] len1;
    logic [1:0]  gnt;
    logic        start;
    logic        err;
  } vec_t;

  localparam logic [31:0] A0 = 32'hA000_0000;
  localparam logic [31:0] A1 = 32'hB000_0010;

  // Job-level reference: pointer rule, latched job, START/DONE timing, count.
  task automatic run_random(input bit ch, input int jobs);
    logic [1:0]  held;
    logic [31:0] ma[2];
    logic [31:0] ml[2];
    logic [1:0]  mlast;
    logic [1:0]  exp_g;
    bit          ptr;
    int          cnt;
    int          win;
    int          d;
    held = '0; ptr = 1'b0; cnt = 0;
    ma[0] = '0; ma[1] = '0; ml[0] = '0; ml[1] = '0;
    do_reset();
    set_ready(ch, 1'b1);
    for (int j = 0; j < jobs; j++) begin
      for (int i = 0; i < 2; i++) begin
        if (!held[i] && ($urandom_range(0, 2) != 0)) begin
          held[i] = 1'b1;
          ma[i] = $urandom;
          ml[i] = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 65535));
          set_job(ch, i, ma[i], ml[i]);
        end
      end
      if (held == 2'b00) begin
        held[0] = 1'b1;
        ma[0] = $urandom;
        ml[0] = 32'h40;
        set_job(ch, 0, ma[0], ml[0]);
      end
      mlast = 2'($urandom_range(0, 3));
      if (!ch) WR_REQ_LAST = mlast;
      set_req(ch, held);
      if ($urandom_range(0, 3) == 0) begin
        set_ready(ch, 1'b0);
        set_int(ch, 1'b1);
        repeat ($urandom_range(1, 3)) begin
          tick();
          check("no grant while not ready", gnt_of(ch), 2'b00);
        end
        set_ready(ch, 1'b1);
        set_int(ch, 1'b0);
      end
      win   = (held == 2'b11) ? int'(ptr) : int'(held[1]);
      exp_g = (win == 1) ? 2'b10 : 2'b01;
      tick();
      check("rand grant", gnt_of(ch), exp_g);
      check("rand latched adrs", adrs_of(ch), ma[win]);
      check("rand latched len", len_of(ch), ml[win]);
      if (!ch) check("rand WR_LAST mirrors granted", WR_LAST, mlast[win]);
      if (ml[win] == 32'd0) begin
        check("rand zero-len no start", start_of(ch), 1'b0);
        check("rand zero-len done", done_of(ch), exp_g);
        check("rand zero-len err", err_of(ch), 1'b1);
      end else begin
        check("rand start", start_of(ch), 1'b1);
        check("rand no early done", done_of(ch), 2'b00);
        tick();
        check("rand start one cycle", start_of(ch), 1'b0);
        d = $urandom_range(0, 6);
        repeat (d) begin
          set_req(ch, 2'($urandom_range(0, 3)));
          tick();
          check("rand busy waits for INT", done_of(ch), 2'b00);
          check("rand grant stable in busy", gnt_of(ch), exp_g);
        end
        set_req(ch, held);
        set_int(ch, 1'b1);
        tick();
        set_int(ch, 1'b0);
        check("rand done", done_of(ch), exp_g);
        check("rand err clear", err_of(ch), 1'b0);
        check("rand grant stable in done", gnt_of(ch), exp_g);
        cnt++;
      end
      held[win] = 1'b0;
      set_req(ch, held);
      tick();
      check("rand done one cycle", done_of(ch), 2'b00);
      check("rand err idle", err_of(ch), 1'b0);
      check("rand grant cleared", gnt_of(ch), 2'b00);
      check("rand count", count_of(ch), 16'(cnt));
      ptr = (win == 0);
    end
  endtask

  initial begin
    vec_t vecs[8];
    logic [1:0] egnt;
    logic [1:0] lv;
    int t;

    vecs[0] = '{1'b0, 2'b11, 32'h10, 32'h20, 2'b00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 2'b00, 32'h10, 32'h20, 2'b00, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 2'b01, 32'h10, 32'h20, 2'b01, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 2'b10, 32'h10, 32'h20, 2'b10, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 2'b11, 32'h10, 32'h20, 2'b01, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 2'b10, 32'h10, 32'h00, 2'b10, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 2'b01, 32'h00, 32'h20, 2'b01, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 2'b11, 32'h00, 32'h05, 2'b01, 1'b0, 1'b1};

    // Reset state.
    do_reset();
    check("reset WR_GNT", WR_GNT, 2'b00);
    check("reset RD_GNT", RD_GNT, 2'b00);
    check("reset WR_COUNT", WR_COUNT, 16'd0);
    check("reset RD_ADRS", RD_ADRS, 32'd0);
    check("reset WR_LAST", WR_LAST, 1'b0);

    // First-decision table, both channels driven identically.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      for (int c = 0; c < 2; c++) begin
        set_job(c[0], 0, A0, vecs[v].len0);
        set_job(c[0], 1, A1, vecs[v].len1);
        set_ready(c[0], vecs[v].ready);
        set_req(c[0], vecs[v].req);
      end
      tick();
      for (int c = 0; c < 2; c++) begin
        egnt = vecs[v].gnt;
        check("vec grant", gnt_of(c[0]), egnt);
        check("vec start", start_of(c[0]), vecs[v].start);
        check("vec done", done_of(c[0]), vecs[v].err ? egnt : 2'b00);
        check("vec err", err_of(c[0]), vecs[v].err);
        check("vec adrs", adrs_of(c[0]), (egnt == 2'b01) ? A0 : (egnt == 2'b10) ? A1 : 32'd0);
      end
    end

    // Single write with INT 20 cycles after START.
    do_reset();
    WR_READY = 1'b1;
    set_job(1'b0, 0, 32'h1000_0000, 32'h1000);
    WR_REQ = 2'b01;
    tick();
    check("single grant", WR_GNT, 2'b01);
    check("single start", WR_START, 1'b1);
    check("single adrs", WR_ADRS, 32'h1000_0000);
    check("single len", WR_LEN, 32'h1000);
    tick();
    check("single start one cycle", WR_START, 1'b0);
    repeat (19) tick();
    check("single no early done", WR_DONE, 2'b00);
    WR_INT = 1'b1;
    tick();
    WR_INT = 1'b0;
    check("single done", WR_DONE, 2'b01);
    check("single err", WR_ERR, 1'b0);
    WR_REQ = 2'b00;
    tick();
    check("single count", WR_COUNT, 16'd1);
    check("single grant released", WR_GNT, 2'b00);

    // Contention: both held, expected order 0,1,0,1.
    do_reset();
    WR_READY = 1'b1;
    set_job(1'b0, 0, A0, 32'h100);
    set_job(1'b0, 1, A1, 32'h200);
    WR_REQ = 2'b11;
    for (int j = 0; j < 4; j++) begin
      t = 0;
      while (WR_START !== 1'b1 && t < 8) begin
        tick();
        t++;
        check("contention never multi-hot", 64'($countones(WR_GNT) <= 1), 64'd1);
      end
      check("contention start seen", WR_START, 1'b1);
      check("contention order", WR_GNT, (j % 2 == 0) ? 2'b01 : 2'b10);
      repeat (5) tick();
      WR_INT = 1'b1;
      tick();
      WR_INT = 1'b0;
      check("contention done", WR_DONE, (j % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Zero-length read on requester 1.
    do_reset();
    RD_READY = 1'b1;
    set_job(1'b1, 1, A1, 32'd0);
    RD_REQ = 2'b10;
    tick();
    check("zero-len RD_DONE", RD_DONE, 2'b10);
    check("zero-len RD_ERR", RD_ERR, 1'b1);
    check("zero-len RD_START", RD_START, 1'b0);
    RD_REQ = 2'b00;
    tick();
    check("zero-len RD_DONE clears", RD_DONE, 2'b00);
    check("zero-len RD_ERR clears", RD_ERR, 1'b0);
    check("zero-len RD_COUNT", RD_COUNT, 16'd0);

    // Concurrency with read gated by RD_READY.
    do_reset();
    WR_READY = 1'b1;
    RD_READY = 1'b0;
    set_job(1'b0, 0, A0, 32'h80);
    set_job(1'b1, 0, A1, 32'h90);
    WR_REQ = 2'b01;
    RD_REQ = 2'b01;
    tick();
    check("concurrent write start", WR_START, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      check("gated read no grant", RD_GNT, 2'b00);
      check("gated read no start", RD_START, 1'b0);
    end
    RD_READY = 1'b1;
    tick();
    check("read start after ready", RD_START, 1'b1);
    check("read grant after ready", RD_GNT, 2'b01);
    WR_INT = 1'b1;
    tick();
    WR_INT = 1'b0;
    check("concurrent write done", WR_DONE, 2'b01);
    WR_REQ = 2'b00;
    RD_INT = 1'b1;
    tick();
    RD_INT = 1'b0;
    check("concurrent read done", RD_DONE, 2'b01);
    check("concurrent WR_COUNT", WR_COUNT, 16'd1);
    RD_REQ = 2'b00;
    tick();
    check("concurrent RD_COUNT", RD_COUNT, 16'd1);

    // Mid-job reset followed by a stray INT.
    do_reset();
    WR_READY = 1'b1;
    set_job(1'b0, 0, A0, 32'h40);
    WR_REQ = 2'b01;
    WR_REQ_LAST = 2'b01;
    tick();
    tick();
    ARESETN = 1'b0;
    WR_REQ = 2'b00;
    #2;
    check("midreset WR_GNT", WR_GNT, 2'b00);
    check("midreset WR_ADRS", WR_ADRS, 32'd0);
    check("midreset WR_LEN", WR_LEN, 32'd0);
    check("midreset WR_LAST", WR_LAST, 1'b0);
    tick();
    ARESETN = 1'b1;
    WR_INT = 1'b1;
    tick();
    WR_INT = 1'b0;
    check("midreset no done", WR_DONE, 2'b00);
    check("midreset count", WR_COUNT, 16'd0);
    WR_REQ = 2'b11;
    set_job(1'b0, 1, A1, 32'h40);
    tick();
    check("midreset idle then grants ptr 0", WR_GNT, 2'b01);
    check("midreset fresh start", WR_START, 1'b1);

    // WR_LAST follows the granted requester only.
    do_reset();
    WR_READY = 1'b1;
    set_job(1'b0, 1, A1, 32'h40);
    WR_REQ_LAST = 2'b11;
    #1;
    check("last without grant", WR_LAST, 1'b0);
    WR_REQ = 2'b10;
    tick();
    for (int k = 0; k < 4; k++) begin
      lv = 2'(k);
      WR_REQ_LAST = lv;
      #1;
      check("last mirrors bit 1", WR_LAST, lv[1]);
    end

    run_random(1'b0, 60);
    run_random(1'b1, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
